sha256_msg_ctrl: RTL and testbench
==================================

# sha256_msg_ctrl

- Message sequencer in front of the SHA-256 compression core.
- Accepts a big-endian 32-bit word stream with a last marker and packs it into 512-bit blocks.
- Performs FIPS 180-4 padding (0x80, zero fill, 64-bit bit length).
- Drives the core's block, start and first-block inputs, waits for the core's done, and returns the final 256-bit digest with a one-cycle done pulse.

## Interface
- TIMEOUT_CYCLES, 1023: maximum cycles in WAIT before abort. Used only with the timeout feature.
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- i_Valid  in  1  input word valid.
- o_Ready  out  1  controller can accept a word.
- i_Word  in  32  message word, first byte in [31:24].
- i_fLast  in  1  word is the last of the message.
- i_LastBytes  in  2  valid bytes in the last word, minus one (0 = 1 byte, 3 = 4 bytes). Left-aligned; ignored unless i_fLast.
- o_CoreData  out  512  block to the core, word 0 in [511:480].
- o_CoreStart  out  1  one-cycle block start to the core.
- o_CoreFirst  out  1  marks the first block of a message; qualified by o_CoreStart.
- i_CoreDone  in  1  core finished the current block.
- i_CoreDigest  in  256  core chaining value, valid with i_CoreDone.
- o_Digest  out  256  final message digest, held until the next o_fDone.
- o_fDone  out  1  one-cycle pulse: o_Digest updated.
- o_Busy  out  1  message in progress (any state but IDLE).
- o_Err  out  1  sticky timeout error.

## Operation
- **States:** IDLE, FILL, ISSUE, WAIT, DIGEST.
- **Handshake:** a word is accepted when i_Valid && o_Ready. o_Ready=1 only in IDLE and FILL.
- **IDLE:**
  - Sets first_blk=1 and clears the word index and the 61-bit byte counter.
  - An accepted word stores to word 0 and moves to FILL (or is handled as the last word if i_fLast).
- **FILL:**
  - Each accepted word goes to buffer[idx]; idx increments and the byte counter adds 4.
  - The 16th word without i_fLast moves to ISSUE with pad_state=NONE.
- **Last word:** the byte counter adds i_LastBytes+1. The word is byte-masked and the 0x80 byte is inserted after the valid bytes; words after it are zeroed.
  - 0x80 lands in the same word and idx ≤ 13: words 14–15 get bit length = bytes×8, as a 64-bit big-endian value. The block is final.
  - 0x80 lands in the same word and idx 14–15: the block is issued; pad_state=ZERO_LEN.
  - 4 bytes at idx 15: no room for 0x80. The block is issued; pad_state=MARK_LEN.
- **ISSUE:**
  - o_CoreStart=1 for exactly one cycle; o_CoreFirst=first_blk.
  - first_blk clears on exit. Next state is WAIT.
- **WAIT:** holds o_CoreData stable; i_CoreDone is sampled only here. On done:
  - Final block: go to DIGEST.
  - pad_state ZERO_LEN: build the block as zeros plus length, then ISSUE.
  - pad_state MARK_LEN: build the block as 0x80000000, zeros, length, then ISSUE.
  - NONE: clear idx and go to FILL.
- **DIGEST:** latches i_CoreDigest into o_Digest, pulses o_fDone, returns to IDLE.
- **Boundaries:**
  - A zero-length message is unsupported; a message has at least one byte.
  - The byte counter wraps modulo 2^61.
  - i_CoreDone outside WAIT is ignored.

## Timing
- **Reset values:** state=IDLE; o_Ready=0 while Rst is high. All other outputs are 0, including o_CoreData, o_Digest and o_Err.
- **Reset mid-message:** discards all state. The core shares Rst.
- **Latencies:**
  - Acceptance of the block-completing word → o_CoreStart: next cycle.
  - i_CoreDone (final block) → o_fDone: next cycle (DIGEST).
  - i_CoreDone (non-final block) → o_Ready: next cycle.
  - i_CoreDone (pad block pending) → o_CoreStart: 2 cycles.
- **Throughput:** one word per cycle in FILL.

## Configuration
- **SHA_CTRL_TIMEOUT_EN defined:**
  - A cycle counter runs in WAIT and clears on entry.
  - Reaching TIMEOUT_CYCLES without i_CoreDone sets o_Err, drops the message and returns to IDLE. No o_fDone is issued.
  - o_Err clears on reset or on the first accepted word of the next message.
- **SHA_CTRL_TIMEOUT_EN undefined:** WAIT holds indefinitely; o_Err is tied 0.

## Structure
- **Package sha256_ctrl_pkg:**
  - State enum and pad_state enum (NONE, ZERO_LEN, MARK_LEN).
  - Constants BLOCK_WORDS=16, LEN_WORD_IDX=14 and PAD_MARK=8'h80.
- **Sub-module sha256_pad_word:** combinational. Takes a word and a valid-byte count and returns the masked word with 0x80 inserted plus a "mark placed" flag.

## Test plan
- **"abc":** 0x61626300, i_fLast, i_LastBytes=2.
  - One o_CoreStart with o_CoreFirst=1 and o_CoreData=61626380_0…0_00000018.
  - o_Digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- **56-byte "abcdbcde…nopq":** 14 words, the last with i_LastBytes=3.
  - Block 1 ends 80000000_00000000 with first=1.
  - Block 2 = 0…0_000001c0 with first=0.
  - o_Digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- **55-byte message:** single block; byte 55=0x80; words 14–15=0x00000000_000001b8.
- **64-byte message:** two blocks. The second = 80000000, zeros, 00000200 (MARK_LEN path).
- **Timeout (macro on):** i_CoreDone held 0.
  - o_Err rises after TIMEOUT_CYCLES in WAIT, state returns to IDLE, no o_fDone.
  - o_Err clears on the next accepted word.
- **Rst pulse during WAIT:** all outputs return to reset values within the reset assertion. A following "abc" yields the correct digest.

Source files
------------

// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 message sequencer.
package sha256_ctrl_pkg;

  localparam int          BLOCK_WORDS  = 16;
  localparam int          LEN_WORD_IDX = 14;
  localparam logic [7:0]  PAD_MARK     = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DIGEST = 3'd4
  } state_e;

  // Padding work still owed after the current block completes.
  typedef enum logic [1:0] {
    PAD_NONE     = 2'd0,
    PAD_ZERO_LEN = 2'd1,
    PAD_MARK_LEN = 2'd2
  } pad_e;

endpackage

// File: rtl/sha256_pad_word.sv
// Masks the final message word to its valid bytes and inserts the 0x80 marker
// after them when it fits in the same word.
module sha256_pad_word
  import sha256_ctrl_pkg::*;
(
  input  logic [31:0] i_Word,
  input  logic [1:0]  i_LastBytes,
  output logic [31:0] o_Word,
  output logic        o_fMark
);

  // NOTE: o_Word gets a full default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_Word = '0;
    for (int b = 0; b < 4; b++) begin
      if (b <= int'(i_LastBytes)) begin
        o_Word[31-8*b -: 8] = i_Word[31-8*b -: 8];
      end else if (b == int'(i_LastBytes) + 1) begin
        o_Word[31-8*b -: 8] = PAD_MARK;
      end
    end
  end

  assign o_fMark = (i_LastBytes != 2'd3);

endmodule

// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message sequencer: packs a 32-bit word stream into padded 512-bit
// blocks, drives the compression core and returns the final digest.
// Optional WAIT-state watchdog enabled by defining SHA_CTRL_TIMEOUT_EN.
module sha256_msg_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [31:0]  i_Word,
  input  logic         i_fLast,
  input  logic [1:0]   i_LastBytes,
  output logic [511:0] o_CoreData,
  output logic         o_CoreStart,
  output logic         o_CoreFirst,
  input  logic         i_CoreDone,
  input  logic [255:0] i_CoreDigest,
  output logic [255:0] o_Digest,
  output logic         o_fDone,
  output logic         o_Busy,
  output logic         o_Err
);

  state_e        r_state;
  pad_e          r_pad;
  logic [31:0]   r_buf [BLOCK_WORDS];
  logic [3:0]    r_idx;
  logic [60:0]   r_bytes;
  logic          r_first;
  logic          r_final;
  logic          r_kick;
  logic [255:0]  r_digest;

  logic [31:0]   w_pad_word;
  logic          w_mark_here;
  logic [4:0]    w_mark_idx;
  logic [60:0]   w_last_bytes;
  logic [63:0]   w_last_len;
  logic [63:0]   w_len;
  logic          w_final;
  logic          w_accept;
  logic          w_abort;

  sha256_pad_word u_pad (
    .i_Word      (i_Word),
    .i_LastBytes (i_LastBytes),
    .o_Word      (w_pad_word),
    .o_fMark     (w_mark_here)
  );

  assign o_Ready      = !Rst && (r_state == ST_IDLE || r_state == ST_FILL);
  assign w_accept     = i_Valid && o_Ready;
  assign w_mark_idx   = {1'b0, r_idx} + {4'd0, !w_mark_here};
  assign w_last_bytes = r_bytes + {59'd0, i_LastBytes} + 61'd1;
  assign w_last_len   = {w_last_bytes, 3'b000};
  assign w_len        = {r_bytes, 3'b000};
  assign w_final      = (w_mark_idx < 5'(LEN_WORD_IDX));

  assign o_CoreStart  = (r_state == ST_ISSUE);
  assign o_CoreFirst  = (r_state == ST_ISSUE) && r_first;
  assign o_fDone      = (r_state == ST_DIGEST);
  assign o_Busy       = (r_state != ST_IDLE);
  assign o_Digest     = r_digest;

  always_comb begin
    o_CoreData = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) o_CoreData[511-32*i -: 32] = r_buf[i];
  end

`ifdef SHA_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;

  assign w_abort = (r_state == ST_WAIT) && !r_kick && !i_CoreDone &&
                   (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign o_Err   = r_err;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept)     r_err <= 1'b0;
      else if (w_abort) r_err <= 1'b1;
      if (r_state == ST_ISSUE)     r_tmo <= '0;
      else if (r_state == ST_WAIT) r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`else
  assign w_abort = 1'b0;
  assign o_Err   = 1'b0;
`endif

  // NOTE: the block buffer sits in the reset domain because o_CoreData is
  // required to read zero out of reset; state updates use <= throughout so
  // every branch sees pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= ST_IDLE;
      r_pad    <= PAD_NONE;
      r_idx    <= '0;
      r_bytes  <= '0;
      r_first  <= 1'b1;
      r_final  <= 1'b0;
      r_kick   <= 1'b0;
      r_digest <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FILL: begin
          if (w_accept && i_fLast) begin
            r_bytes <= w_last_bytes;
            r_final <= w_final;
            r_pad   <= (w_mark_idx == 5'd16) ? PAD_MARK_LEN :
                       (w_final ? PAD_NONE : PAD_ZERO_LEN);
            // Words past the last one hold the marker, zero fill or length.
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              if (i == int'(r_idx))                          r_buf[i] <= w_pad_word;
              else if (i > int'(r_idx)) begin
                if (i == int'(w_mark_idx))                   r_buf[i] <= {PAD_MARK, 24'h0};
                else if (w_final && i == LEN_WORD_IDX)       r_buf[i] <= w_last_len[63:32];
                else if (w_final && i == LEN_WORD_IDX + 1)   r_buf[i] <= w_last_len[31:0];
                else                                         r_buf[i] <= '0;
              end
            end
            r_state <= ST_ISSUE;
          end else if (w_accept) begin
            r_buf[r_idx] <= i_Word;
            r_idx        <= r_idx + 4'd1;
            r_bytes      <= r_bytes + 61'd4;
            r_final      <= 1'b0;
            r_pad        <= PAD_NONE;
            r_state      <= (r_idx == 4'd15) ? ST_ISSUE : ST_FILL;
          end
        end
        ST_ISSUE: begin
          r_first <= 1'b0;
          r_kick  <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_kick) begin
            r_state <= ST_ISSUE;
          end else if (i_CoreDone) begin
            if (r_final) begin
              r_digest <= i_CoreDigest;
              r_state  <= ST_DIGEST;
            end else if (r_pad != PAD_NONE) begin
              for (int i = 0; i < BLOCK_WORDS; i++) begin
                if (i == 0 && r_pad == PAD_MARK_LEN) r_buf[i] <= {PAD_MARK, 24'h0};
                else if (i == LEN_WORD_IDX)          r_buf[i] <= w_len[63:32];
                else if (i == LEN_WORD_IDX + 1)      r_buf[i] <= w_len[31:0];
                else                                 r_buf[i] <= '0;
              end
              r_pad   <= PAD_NONE;
              r_final <= 1'b1;
              r_kick  <= 1'b1;
            end else begin
              r_idx   <= '0;
              r_state <= ST_FILL;
            end
          end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_pad   <= PAD_NONE;
            r_idx   <= '0;
            r_bytes <= '0;
            r_first <= 1'b1;
          end
        end
        ST_DIGEST: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_bytes <= '0;
          r_first <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Self-checking bench for sha256_msg_ctrl: padding reference model, behavioural
// SHA-256 core, and a scoreboard monitor for blocks and digests.
module tb_sha256_msg_ctrl;

  localparam int TMO = 1023;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [511:0] data;
    bit           first;
    bit           pad_only;
  } exp_t;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         Clk, Rst;
  logic         i_Valid, o_Ready, i_fLast;
  logic [31:0]  i_Word;
  logic [1:0]   i_LastBytes;
  logic [511:0] o_CoreData;
  logic         o_CoreStart, o_CoreFirst, i_CoreDone;
  logic [255:0] i_CoreDigest, o_Digest;
  logic         o_fDone, o_Busy, o_Err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cyc = 0;
  int   start_cyc = 0;
  bit   stall    = 0;
  exp_t         exp_q [$];
  logic [255:0] dig_q [$];

  sha256_msg_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Rst(Rst), .i_Valid(i_Valid), .o_Ready(o_Ready), .i_Word(i_Word),
    .i_fLast(i_fLast), .i_LastBytes(i_LastBytes), .o_CoreData(o_CoreData),
    .o_CoreStart(o_CoreStart), .o_CoreFirst(o_CoreFirst), .i_CoreDone(i_CoreDone),
    .i_CoreDigest(i_CoreDigest), .o_Digest(o_Digest), .o_fDone(o_fDone),
    .o_Busy(o_Busy), .o_Err(o_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7] +
             (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic bq_t rand_msg(input int len);
    bq_t m;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  // Behavioural core: random latency, real compression, optional stall, and
  // stray done pulses while the controller is accepting words.
  initial begin
    bit           pend = 0;
    int           busy_cnt = 0;
    logic [255:0] h_chain = IV;
    logic [255:0] h_res = '0;
    i_CoreDone = 1'b0;
    i_CoreDigest = '0;
    forever begin
      @(negedge Clk);
      i_CoreDone = 1'b0;
      if (Rst) begin
        pend = 0;
      end else if (o_CoreStart) begin
        h_res    = sha_compress(o_CoreFirst ? IV : h_chain, o_CoreData);
        h_chain  = h_res;
        pend     = 1;
        busy_cnt = $urandom_range(1, 5);
      end else if (!o_Busy) begin
        pend = 0;
        if (o_Ready && $urandom_range(0, 7) == 0) begin
          i_CoreDone   = 1'b1;
          i_CoreDigest = {8{$urandom}};
        end
      end else if (pend && !stall) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          i_CoreDone   = 1'b1;
          i_CoreDigest = h_res;
          pend         = 0;
          done_cyc     = cyc;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    logic [255:0] d;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        if (o_CoreStart) begin
          if (exp_q.size() == 0) check(0, "unexpected_start", o_CoreData, '0);
          else begin
            e = exp_q.pop_front();
            check(o_CoreData === e.data, "block", o_CoreData, e.data);
            check(o_CoreFirst === e.first, "first", 512'(o_CoreFirst), 512'(e.first));
            if (e.pad_only) check(cyc == done_cyc + 2, "pad_latency", 512'(cyc), 512'(done_cyc + 2));
          end
          start_cyc = cyc;
        end
        if (o_fDone) begin
          if (dig_q.size() == 0) check(0, "unexpected_done", 512'(o_Digest), '0);
          else begin
            d = dig_q.pop_front();
            check(o_Digest === d, "digest", 512'(o_Digest), 512'(d));
            check(cyc == done_cyc + 1, "done_latency", 512'(cyc), 512'(done_cyc + 1));
          end
        end
      end
    end
  end

  task automatic send_msg(input bq_t msg, input bit use_known, input logic [255:0] known, input bit want_digest);
    bq_t          pad;
    exp_t         e;
    logic [511:0] blk;
    logic [255:0] h;
    logic [63:0]  bitlen;
    logic [31:0]  word;
    int len, nw, last_blk, n;
    len = msg.size();
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bitlen = 64'(len) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(bitlen[8*k +: 8]);
    last_blk = (len - 1) / 64;
    h = IV;
    for (int b = 0; b < pad.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*b + j];
      e.data = blk;
      e.first = (b == 0);
      e.pad_only = (b > last_blk);
      exp_q.push_back(e);
      h = sha_compress(h, blk);
    end
    if (want_digest) dig_q.push_back(use_known ? known : h);
    nw = (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) word[31-8*k -: 8] = (4*w + k < len) ? msg[4*w + k] : 8'($urandom);
      if ($urandom_range(0, 3) == 0) @(negedge Clk);
      i_Valid     = 1'b1;
      i_Word      = word;
      i_fLast     = (w == nw - 1);
      i_LastBytes = (w == nw - 1) ? 2'((len - 1) % 4) : 2'($urandom);
      n = 0;
      while (!o_Ready && n < 200) begin
        @(negedge Clk);
        n++;
      end
      if (!o_Ready) begin
        check(0, "ready_timeout", 512'(n), 512'(200));
        i_Valid = 1'b0;
        return;
      end
      @(negedge Clk);
      i_Valid = 1'b0;
      i_fLast = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || dig_q.size() != 0 || o_Busy) && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    check(n < 2000, "drain", 512'(n), 512'(2000));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(o_Ready == 1'b0 && o_CoreStart == 1'b0 && o_CoreFirst == 1'b0, {tag, "_ctl"},
          512'({o_Ready, o_CoreStart, o_CoreFirst}), '0);
    check(o_CoreData == '0, {tag, "_data"}, o_CoreData, '0);
    check(o_Digest == '0, {tag, "_digest"}, 512'(o_Digest), '0);
    check(o_fDone == 1'b0 && o_Busy == 1'b0 && o_Err == 1'b0, {tag, "_status"},
          512'({o_fDone, o_Busy, o_Err}), '0);
  endtask

  initial begin
    bq_t abc, m56;
    int  lens [17] = '{1, 2, 3, 4, 5, 52, 57, 59, 60, 61, 62, 63, 65, 119, 120, 128, 200};
    int  n;
    logic [255:0] abc_dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    logic [255:0] m56_dig = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    abc = '{8'h61, 8'h62, 8'h63};
    for (int i = 0; i < 14; i++)
      for (int k = 0; k < 4; k++) m56.push_back(8'(8'h61 + i + k));

    Rst = 1'b1; i_Valid = 1'b0; i_Word = '0; i_fLast = 1'b0; i_LastBytes = '0;
    repeat (2) @(negedge Clk);
    check_reset_outputs("reset");
    Rst = 1'b0;
    @(negedge Clk);
    check(o_Ready == 1'b1, "ready_after_reset", 512'(o_Ready), 512'(1));

    send_msg(abc, 1, abc_dig, 1);
    send_msg(m56, 1, m56_dig, 1);
    send_msg(rand_msg(55), 0, '0, 1);
    send_msg(rand_msg(64), 0, '0, 1);
    foreach (lens[i]) send_msg(rand_msg(lens[i]), 0, '0, 1);
    for (int i = 0; i < 6; i++) send_msg(rand_msg($urandom_range(1, 180)), 0, '0, 1);
    drain();

    // Reset while the core is still working on a block.
    stall = 1;
    send_msg(abc, 0, '0, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    repeat (3) @(negedge Clk);
    check(o_Busy == 1'b1, "busy_in_wait", 512'(o_Busy), 512'(1));
    Rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    stall = 0;
    exp_q.delete();
    dig_q.delete();
    send_msg(abc, 1, abc_dig, 1);
    drain();

`ifdef SHA_CTRL_TIMEOUT_EN
    stall = 1;
    send_msg(abc, 0, '0, 0);
    n = 0;
    while (!o_Err && n < TMO + 50) begin
      @(negedge Clk);
      n++;
    end
    check(o_Err == 1'b1, "err_set", 512'(o_Err), 512'(1));
    check(cyc - start_cyc >= TMO && cyc - start_cyc <= TMO + 2, "timeout_cycles",
          512'(cyc - start_cyc), 512'(TMO + 1));
    check(o_Busy == 1'b0, "idle_after_timeout", 512'(o_Busy), '0);
    stall = 0;
    send_msg(abc, 1, abc_dig, 1);
    check(o_Err == 1'b0, "err_clear", 512'(o_Err), '0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
